matrix_loader: RTL and testbench

MATRIX_LOADER -- requirements
Module: matrix_loader

---
 rtl/matrix_loader_pkg.sv | 26 ++
 rtl/matrix_loader_if.sv | 33 +++
 rtl/matrix_loader.sv | 127 ++++++++++++
 tb/tb_matrix_loader.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/matrix_loader_pkg.sv
// -----------------------------------------------------------------------------
// matrix_loader_pkg
// Shared definitions for the matrix loader and the downstream multiplier:
//   - loader state encoding (state_t)
//   - default operand geometry (DEF_MATRIX_N, DEF_MATRIX_M, DEF_WIDTH)
//   - idx_width(): index counter width for a given element count
// -----------------------------------------------------------------------------
package matrix_loader_pkg;

   localparam int DEF_MATRIX_N = 3;
   localparam int DEF_MATRIX_M = 3;
   localparam int DEF_WIDTH    = 16;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOAD_A = 2'd1,
      LOAD_B = 2'd2,
      READY  = 2'd3
   } state_t;

   // A 1x1 matrix still needs a 1-bit index so the counter has a legal width.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/matrix_loader_if.sv
// -----------------------------------------------------------------------------
// matrix_loader_if
// Word-stream handshake feeding the matrix loader.
//   in_data  : one unsigned matrix element per accepted word
//   in_valid : in_data is valid
//   in_first : word is element A(0,0), start of a frame
//   in_ready : loader accepts a word this cycle
// Modports: master = word source, slave = loader.
// -----------------------------------------------------------------------------
interface matrix_loader_if
   import matrix_loader_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
);
   logic [WIDTH-1:0] in_data;
   logic             in_valid;
   logic             in_first;
   logic             in_ready;

   modport master (
      output in_data,
      output in_valid,
      output in_first,
      input  in_ready
   );

   modport slave (
      input  in_data,
      input  in_valid,
      input  in_first,
      output in_ready
   );
endinterface

// File: rtl/matrix_loader.sv
// -----------------------------------------------------------------------------
// matrix_loader
// Collects a frame of MATRIX_N*MATRIX_M words for operand A followed by the
// same number for operand B (row-major), then presents both packed operands
// to the multiplier until it signals compute_done.
// Ports:
//   clk, reset   : clock, asynchronous active-high reset
//   in_if        : word stream (slave modport)
//   compute_done : multiplier finished with the current operands
//   matrix_a/b   : packed operands, element (r,c) at [(r*M+c)*WIDTH +: WIDTH]
//   read_ready   : operands complete and stable
//   frame_err    : one-cycle pulse on a framing violation
// -----------------------------------------------------------------------------
module matrix_loader
   import matrix_loader_pkg::*;
#(
   parameter int MATRIX_N = DEF_MATRIX_N,
   parameter int MATRIX_M = DEF_MATRIX_M,
   parameter int WIDTH    = DEF_WIDTH
) (
   input  logic                               clk,
   input  logic                               reset,
   matrix_loader_if.slave                     in_if,
   input  logic                               compute_done,
   output logic [MATRIX_N*MATRIX_M*WIDTH-1:0] matrix_a,
   output logic [MATRIX_N*MATRIX_M*WIDTH-1:0] matrix_b,
   output logic                               read_ready,
   output logic                               frame_err
);

   localparam int ELEMS = MATRIX_N * MATRIX_M;
   localparam int IDX_W = idx_width(ELEMS);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ELEMS - 1);

   state_t           state_q, state_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [IDX_W-1:0] wr_idx;
   logic             active_q;
   logic             accept;
   logic             we_a, we_b;
   logic             err_d;

   // active_q holds in_ready low during reset and releases it on the first
   // edge afterwards; ready is a pure decode of registers, never of in_valid.
   assign in_if.in_ready = active_q && (state_q != READY);
   assign accept         = in_if.in_valid && in_if.in_ready;
   assign read_ready     = (state_q == READY);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         idx_q    <= '0;
         active_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         active_q <= 1'b1;
      end
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      wr_idx  = idx_q;
      we_a    = 1'b0;
      we_b    = 1'b0;
      err_d   = 1'b0;
      case (state_q)
         IDLE, LOAD_A, LOAD_B: begin
            if (accept) begin
               if (in_if.in_first) begin
                  // Start (or restart) of a frame: always lands on A(0,0).
                  we_a   = 1'b1;
                  wr_idx = '0;
                  err_d  = (state_q != IDLE);
               end else if (state_q == IDLE) begin
                  err_d = 1'b1;
               end else if (state_q == LOAD_A) begin
                  we_a = 1'b1;
               end else begin
                  we_b = 1'b1;
               end

               if (we_a) begin
                  if (wr_idx == LAST_IDX) begin
                     idx_d   = '0;
                     state_d = LOAD_B;
                  end else begin
                     idx_d   = wr_idx + 1'b1;
                     state_d = LOAD_A;
                  end
               end else if (we_b) begin
                  if (wr_idx == LAST_IDX) begin
                     idx_d   = '0;
                     state_d = READY;
                  end else begin
                     idx_d = wr_idx + 1'b1;
                  end
               end
            end
         end
         READY: begin
            if (compute_done) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         matrix_a  <= '0;
         matrix_b  <= '0;
         frame_err <= 1'b0;
      end else begin
         frame_err <= err_d;
         if (we_a) begin
            matrix_a[int'(wr_idx)*WIDTH +: WIDTH] <= in_if.in_data;
         end
         if (we_b) begin
            matrix_b[int'(wr_idx)*WIDTH +: WIDTH] <= in_if.in_data;
         end
      end
   end

endmodule

// File: tb/tb_matrix_loader.sv
// -----------------------------------------------------------------------------
// tb_matrix_loader
// Self-checking bench for matrix_loader with a frame-level reference model.
// -----------------------------------------------------------------------------
module tb_matrix_loader;
   import matrix_loader_pkg::*;

   localparam int N  = 3;
   localparam int M  = 3;
   localparam int W  = 16;
   localparam int E  = N * M;
   localparam int VW = E * W;

   logic          clk = 1'b0;
   logic          reset;
   logic          compute_done;
   logic [VW-1:0] matrix_a, matrix_b;
   logic          read_ready, frame_err;

   matrix_loader_if #(.WIDTH(W)) in_if ();

   matrix_loader #(.MATRIX_N(N), .MATRIX_M(M), .WIDTH(W)) dut (
      .clk          (clk),
      .reset        (reset),
      .in_if        (in_if),
      .compute_done (compute_done),
      .matrix_a     (matrix_a),
      .matrix_b     (matrix_b),
      .read_ready   (read_ready),
      .frame_err    (frame_err)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: a frame is just a count of accepted words since the
   // last in_first word; the first E go to A, the next E to B.
   logic [W-1:0] m_a [E];
   logic [W-1:0] m_b [E];
   int           m_count;
   bit           m_loading, m_ready, m_err, m_active;

   task automatic check_eq(input string tag, input logic [VW-1:0] got, input logic [VW-1:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [VW-1:0] pack(input logic [W-1:0] v [E]);
      logic [VW-1:0] r;
      r = '0;
      for (int k = 0; k < E; k++) r[k*W +: W] = v[k];
      return r;
   endfunction

   task automatic model_clear();
      for (int k = 0; k < E; k++) begin
         m_a[k] = '0;
         m_b[k] = '0;
      end
      m_count = 0; m_loading = 0; m_ready = 0; m_err = 0; m_active = 0;
   endtask

   task automatic model_step();
      bit acc;
      acc   = in_if.in_valid && m_active && !m_ready;
      m_err = 0;
      if (m_ready) begin
         if (compute_done) m_ready = 0;
      end else if (acc) begin
         if (in_if.in_first) begin
            if (m_loading) m_err = 1;
            m_a[0]    = in_if.in_data;
            m_count   = 1;
            m_loading = 1;
         end else if (!m_loading) begin
            m_err = 1;
         end else begin
            if (m_count < E) m_a[m_count] = in_if.in_data;
            else             m_b[m_count-E] = in_if.in_data;
            m_count++;
         end
         if (m_loading && m_count == 2*E) begin
            m_loading = 0;
            m_ready   = 1;
         end
      end
      m_active = 1;
   endtask

   task automatic check_outputs();
      check_eq("in_ready",   VW'(in_if.in_ready), VW'(m_active && !m_ready));
      check_eq("read_ready", VW'(read_ready),     VW'(m_ready));
      check_eq("frame_err",  VW'(frame_err),      VW'(m_err));
      check_eq("matrix_a",   matrix_a,            pack(m_a));
      check_eq("matrix_b",   matrix_b,            pack(m_b));
   endtask

   task automatic cycle();
      @(posedge clk);
      model_step();
      @(negedge clk);
      check_outputs();
   endtask

   task automatic idle(input int n);
      in_if.in_valid = 1'b0;
      in_if.in_first = 1'b0;
      for (int i = 0; i < n; i++) cycle();
   endtask

   task automatic send(input logic [W-1:0] d, input logic f);
      bit acc;
      in_if.in_valid = 1'b1;
      in_if.in_data  = d;
      in_if.in_first = f;
      for (int i = 0; i < 8; i++) begin
         acc = m_active && !m_ready;
         cycle();
         if (acc) return;
      end
      check_eq("send_timeout", VW'(0), VW'(1));
   endtask

   task automatic do_reset();
      reset          = 1'b1;
      in_if.in_valid = 1'b0;
      in_if.in_first = 1'b0;
      compute_done   = 1'b0;
      model_clear();
      #1;
      check_outputs();
      @(posedge clk);
      @(negedge clk);
      check_outputs();
      reset = 1'b0;
   endtask

   task automatic release_operands();
      compute_done = 1'b1;
      cycle();
      compute_done   = 1'b0;
      in_if.in_valid = 1'b0;
      in_if.in_first = 1'b0;
      cycle();
   endtask

   task automatic run_frame(input logic [W-1:0] w [2*E], input bit gaps);
      for (int k = 0; k < 2*E; k++) begin
         if (gaps && $urandom_range(0, 1) == 1) idle($urandom_range(1, 2));
         send(w[k], k == 0);
      end
   endtask

   logic [W-1:0]  seq [2*E];
   logic [W-1:0]  rnd [2*E];
   logic [W-1:0]  ea [E];
   logic [W-1:0]  eb [E];
   logic [VW-1:0] snap_a, snap_b;

   initial begin
      in_if.in_data  = '0;
      in_if.in_valid = 1'b0;
      in_if.in_first = 1'b0;
      compute_done   = 1'b0;
      reset          = 1'b0;
      @(negedge clk);
      do_reset();
      idle(2);

      // Incrementing frame 1..18; cross-check against fixed constants too.
      for (int k = 0; k < 2*E; k++) seq[k] = W'(k + 1);
      for (int k = 0; k < E; k++) begin
         ea[k] = W'(k + 1);
         eb[k] = W'(k + 1 + E);
      end
      run_frame(seq, 0);
      check_eq("seq_ready", VW'(read_ready), VW'(1));
      check_eq("seq_a", matrix_a, pack(ea));
      check_eq("seq_b", matrix_b, pack(eb));

      // Pushing words while holding operands: nothing accepted or changed.
      snap_a = pack(ea);
      snap_b = pack(eb);
      in_if.in_valid = 1'b1;
      in_if.in_first = 1'b1;
      in_if.in_data  = 16'hBEEF;
      for (int i = 0; i < 5; i++) cycle();
      check_eq("hold_a", matrix_a, snap_a);
      check_eq("hold_b", matrix_b, snap_b);
      release_operands();
      check_eq("released_ready", VW'(in_if.in_ready), VW'(1));

      // Restart after four words.
      for (int k = 0; k < 4; k++) send(W'(16'h0100 + k), k == 0);
      send(16'h00AA, 1'b1);
      check_eq("restart_err", VW'(frame_err), VW'(1));
      check_eq("restart_a00", VW'(matrix_a[W-1:0]), VW'(16'h00AA));
      for (int k = 1; k < 2*E; k++) send(W'(16'h0200 + k), 1'b0);
      check_eq("restart_ready", VW'(read_ready), VW'(1));
      release_operands();

      // Stray word in IDLE without in_first.
      snap_a = matrix_a;
      send(16'h1234, 1'b0);
      check_eq("stray_err", VW'(frame_err), VW'(1));
      idle(1);
      check_eq("stray_idle_ready", VW'(in_if.in_ready), VW'(1));

      // Reset mid-frame, then a clean frame.
      for (int k = 0; k < 12; k++) send(seq[k], k == 0);
      @(negedge clk);
      do_reset();
      check_eq("rst_a", matrix_a, '0);
      check_eq("rst_b", matrix_b, '0);
      idle(1);
      run_frame(seq, 0);
      check_eq("post_rst_a", matrix_a, pack(ea));
      check_eq("post_rst_b", matrix_b, pack(eb));
      release_operands();

      // Random words, back-to-back then with random valid gaps.
      for (int k = 0; k < 2*E; k++) rnd[k] = W'($urandom);
      for (int k = 0; k < E; k++) begin
         ea[k] = rnd[k];
         eb[k] = rnd[k+E];
      end
      run_frame(rnd, 0);
      check_eq("b2b_a", matrix_a, pack(ea));
      check_eq("b2b_b", matrix_b, pack(eb));
      release_operands();
      for (int rep = 0; rep < 4; rep++) begin
         run_frame(rnd, 1);
         check_eq("gap_a", matrix_a, pack(ea));
         check_eq("gap_b", matrix_b, pack(eb));
         release_operands();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
